// File: rtl/lte_ul_ant_deintlv.sv
// Uplink antenna de-interleaver with frame-sync keeper (HUNT/CHECK/LOCK, flywheel).
// Optional per-frame antenna power accumulator enabled by defining LTE_UL_ANT_PWR_EN.
module lte_ul_ant_deintlv #(
  parameter int unsigned FRAME_LEN = 4915200,
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic        asy_rst,
  input  logic        clk,
  input  logic [31:0] i_data_iq,
  input  logic        i_fram_hd,
  input  logic        i_ant8_sel,
  input  logic [7:0]  i_ant_mask,
  input  logic [2:0]  i_pwr_ant,
  output logic [31:0] o_ant_iq,
  output logic [2:0]  o_ant_idx,
  output logic        o_ant_vld,
  output logic        o_frm_start,
  output logic [9:0]  o_frm_num,
  output logic [1:0]  o_sync_st,
  output logic [15:0] o_sync_err,
  output logic [15:0] o_slot_err,
  output logic [51:0] o_pwr_acc,
  output logic        o_pwr_vld
);

  localparam logic [1:0]  ST_HUNT   = 2'd0;
  localparam logic [1:0]  ST_CHECK  = 2'd1;
  localparam logic [1:0]  ST_LOCK   = 2'd2;
  localparam logic [23:0] FCNT_LAST = 24'(FRAME_LEN - 1);
  localparam logic [7:0]  ERR_MAX   = 8'(ERR_LIMIT);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) sat_inc = v;
    else               sat_inc = v + 16'd1;
  endfunction

  logic [31:0] data_r;
  logic        hd_r;
  logic        sel_r;
  logic [7:0]  mask_r;
  logic [2:0]  slot_r;
  logic [23:0] fcnt_r;
  logic [1:0]  state_r;
  logic [7:0]  err_cnt_r;

  logic [2:0]  cur_slot_s;
  logic        slip_s;
  logic [1:0]  state_nxt_s;
  logic [23:0] fcnt_nxt_s;
  logic [7:0]  err_nxt_s;
  logic        frm_start_s;
  logic        frm_first_s;
  logic        sync_err_s;
  logic        vld_s;

  // Input registration stage.
  always_ff @(posedge clk or posedge asy_rst) begin
    if (asy_rst) begin
      data_r <= 32'd0;
      hd_r   <= 1'b0;
      sel_r  <= 1'b0;
      mask_r <= 8'd0;
    end else begin
      data_r <= i_data_iq;
      hd_r   <= i_fram_hd;
      sel_r  <= i_ant8_sel;
      mask_r <= i_ant_mask;
    end
  end

  // Slot of the current stage-1 sample; a marker off the natural wrap is a slip.
  always_comb begin
    cur_slot_s = slot_r + 3'd1;
    slip_s     = 1'b0;
    if (sel_r) begin
      cur_slot_s = 3'd0;
      slip_s     = (slot_r != 3'd7);
    end else begin
      cur_slot_s = slot_r + 3'd1;
      slip_s     = 1'b0;
    end
  end

  // Frame-sync next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    fcnt_nxt_s  = fcnt_r + 24'd1;
    err_nxt_s   = err_cnt_r;
    frm_start_s = 1'b0;
    frm_first_s = 1'b0;
    sync_err_s  = 1'b0;
    case (state_r)
      ST_HUNT: begin
        fcnt_nxt_s = 24'd0;
        err_nxt_s  = 8'd0;
        if (hd_r) state_nxt_s = ST_CHECK;
        else      state_nxt_s = ST_HUNT;
      end
      ST_CHECK: begin
        if (hd_r) begin
          fcnt_nxt_s = 24'd0;
          if (fcnt_r == FCNT_LAST) begin
            state_nxt_s = ST_LOCK;
            frm_start_s = 1'b1;
            frm_first_s = 1'b1;
            err_nxt_s   = 8'd0;
          end else begin
            state_nxt_s = ST_CHECK;
          end
        end else if (fcnt_r == FCNT_LAST) begin
          state_nxt_s = ST_HUNT;
          fcnt_nxt_s  = 24'd0;
        end else begin
          state_nxt_s = ST_CHECK;
        end
      end
      ST_LOCK: begin
        if (hd_r || (fcnt_r == FCNT_LAST)) begin
          fcnt_nxt_s = 24'd0;
          if (hd_r && (fcnt_r == FCNT_LAST)) begin
            frm_start_s = 1'b1;
            err_nxt_s   = 8'd0;
          end else begin
            // Early or missing header; the limit-reaching error drops lock and its frame start.
            sync_err_s = 1'b1;
            if ((err_cnt_r + 8'd1) >= ERR_MAX) begin
              state_nxt_s = ST_HUNT;
              err_nxt_s   = 8'd0;
            end else begin
              err_nxt_s   = err_cnt_r + 8'd1;
              frm_start_s = 1'b1;
            end
          end
        end else begin
          state_nxt_s = ST_LOCK;
        end
      end
      default: begin
        state_nxt_s = ST_HUNT;
        fcnt_nxt_s  = 24'd0;
        err_nxt_s   = 8'd0;
      end
    endcase
    vld_s = (state_nxt_s == ST_LOCK) && mask_r[cur_slot_s];
  end

  // Slot, frame counter and sync state registers.
  always_ff @(posedge clk or posedge asy_rst) begin
    if (asy_rst) begin
      slot_r    <= 3'd7;
      fcnt_r    <= 24'd0;
      state_r   <= ST_HUNT;
      err_cnt_r <= 8'd0;
    end else begin
      slot_r    <= cur_slot_s;
      fcnt_r    <= fcnt_nxt_s;
      state_r   <= state_nxt_s;
      err_cnt_r <= err_nxt_s;
    end
  end

  assign o_sync_st = state_r;

  // Output stage: sample, tags and status counters.
  always_ff @(posedge clk or posedge asy_rst) begin
    if (asy_rst) begin
      o_ant_iq    <= 32'd0;
      o_ant_idx   <= 3'd0;
      o_ant_vld   <= 1'b0;
      o_frm_start <= 1'b0;
      o_frm_num   <= 10'd0;
      o_sync_err  <= 16'd0;
      o_slot_err  <= 16'd0;
    end else begin
      o_ant_iq    <= data_r;
      o_ant_idx   <= cur_slot_s;
      o_ant_vld   <= vld_s;
      o_frm_start <= frm_start_s;
      if (frm_first_s)      o_frm_num <= 10'd0;
      else if (frm_start_s) o_frm_num <= o_frm_num + 10'd1;
      if (sync_err_s) o_sync_err <= sat_inc(o_sync_err);
      if (slip_s)     o_slot_err <= sat_inc(o_slot_err);
    end
  end

`ifdef LTE_UL_ANT_PWR_EN
  logic [2:0]         pwr_ant_r;
  logic [31:0]        pw_iq_r;
  logic               pw_take_r;
  logic               pw_fs_r;
  logic signed [31:0] sq_i_r;
  logic signed [31:0] sq_q_r;
  logic               sq_take_r;
  logic               sq_fs_r;
  logic [31:0]        sum_r;
  logic               sum_take_r;
  logic               sum_fs_r;
  logic [51:0]        acc_r;
  logic [51:0]        pwr_acc_r;
  logic               pwr_vld_r;
  logic signed [31:0] i_ext_s;
  logic signed [31:0] q_ext_s;
  logic [51:0]        term_s;

  always_comb begin
    i_ext_s = {{16{pw_iq_r[31]}}, pw_iq_r[31:16]};
    q_ext_s = {{16{pw_iq_r[15]}}, pw_iq_r[15:0]};
    term_s  = sum_take_r ? {20'd0, sum_r} : 52'd0;
  end

  // Squarer and accumulator pipeline, three stages behind the frame-start output.
  always_ff @(posedge clk or posedge asy_rst) begin
    if (asy_rst) begin
      pwr_ant_r  <= 3'd0;
      pw_iq_r    <= 32'd0;
      pw_take_r  <= 1'b0;
      pw_fs_r    <= 1'b0;
      sq_i_r     <= 32'sd0;
      sq_q_r     <= 32'sd0;
      sq_take_r  <= 1'b0;
      sq_fs_r    <= 1'b0;
      sum_r      <= 32'd0;
      sum_take_r <= 1'b0;
      sum_fs_r   <= 1'b0;
      acc_r      <= 52'd0;
      pwr_acc_r  <= 52'd0;
      pwr_vld_r  <= 1'b0;
    end else begin
      pwr_ant_r  <= i_pwr_ant;
      pw_iq_r    <= data_r;
      pw_take_r  <= (state_nxt_s == ST_LOCK) && (cur_slot_s == pwr_ant_r);
      pw_fs_r    <= frm_start_s;
      sq_i_r     <= i_ext_s * i_ext_s;
      sq_q_r     <= q_ext_s * q_ext_s;
      sq_take_r  <= pw_take_r;
      sq_fs_r    <= pw_fs_r;
      sum_r      <= $unsigned(sq_i_r) + $unsigned(sq_q_r);
      sum_take_r <= sq_take_r;
      sum_fs_r   <= sq_fs_r;
      if (sum_fs_r) begin
        pwr_acc_r <= acc_r;
        acc_r     <= term_s;
        pwr_vld_r <= 1'b1;
      end else begin
        acc_r     <= acc_r + term_s;
        pwr_vld_r <= 1'b0;
      end
    end
  end

  assign o_pwr_acc = pwr_acc_r;
  assign o_pwr_vld = pwr_vld_r;
`else
  logic unused_pwr_s;
  assign unused_pwr_s = ^i_pwr_ant;
  assign o_pwr_acc    = 52'd0;
  assign o_pwr_vld    = 1'b0;
`endif

endmodule

// File: tb/tb_lte_ul_ant_deintlv.sv
// Scoreboard bench for lte_ul_ant_deintlv with FRAME_LEN=64: acquisition, flywheel,
// error-limit drop, slot slip, mask, power (when LTE_UL_ANT_PWR_EN) and mid-lock reset.
module tb_lte_ul_ant_deintlv;

  typedef struct {
    logic [31:0] iq;
    logic [2:0]  idx;
    logic        fs;
    logic [9:0]  fnum;
  } exp_t;

  logic        clk = 1'b0;
  logic        asy_rst;
  logic [31:0] i_data_iq;
  logic        i_fram_hd;
  logic        i_ant8_sel;
  logic [7:0]  i_ant_mask;
  logic [2:0]  i_pwr_ant;
  logic [31:0] o_ant_iq;
  logic [2:0]  o_ant_idx;
  logic        o_ant_vld;
  logic        o_frm_start;
  logic [9:0]  o_frm_num;
  logic [1:0]  o_sync_st;
  logic [15:0] o_sync_err;
  logic [15:0] o_slot_err;
  logic [51:0] o_pwr_acc;
  logic        o_pwr_vld;

  int checks   = 0;
  int failures = 0;
  exp_t        sb_q[$];
  logic [51:0] pw_q[$];
  exp_t        mon_e;
  logic [51:0] mon_p;

  always #5 clk = ~clk;

  lte_ul_ant_deintlv #(.FRAME_LEN(64), .ERR_LIMIT(3)) dut (
    .asy_rst(asy_rst), .clk(clk),
    .i_data_iq(i_data_iq), .i_fram_hd(i_fram_hd), .i_ant8_sel(i_ant8_sel),
    .i_ant_mask(i_ant_mask), .i_pwr_ant(i_pwr_ant),
    .o_ant_iq(o_ant_iq), .o_ant_idx(o_ant_idx), .o_ant_vld(o_ant_vld),
    .o_frm_start(o_frm_start), .o_frm_num(o_frm_num), .o_sync_st(o_sync_st),
    .o_sync_err(o_sync_err), .o_slot_err(o_slot_err),
    .o_pwr_acc(o_pwr_acc), .o_pwr_vld(o_pwr_vld)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Epoch 0: headers every 64 from c=7 (dropped at 199, 327, 391, 455), marker
  // shifted by +3 from c=602, mask A5 from c=560. Epoch 1: after reset, headers at 7 and 71.
  task automatic drive(input int epoch, input int c);
    int          bs;
    logic        hd, lock, fs;
    logic [7:0]  mask;
    logic [9:0]  fnum;
    logic [2:0]  bs3;
    logic [15:0] c16;
    exp_t        e;
    if (epoch == 0 && c >= 602) bs = (c - 602) % 8;
    else                        bs = (c + 1) % 8;
    if (epoch == 0) begin
      hd   = (c >= 7) && ((c - 7) % 64 == 0) && !(c == 199 || c == 327 || c == 391 || c == 455);
      lock = (c >= 71 && c <= 454) || (c >= 583);
      fs   = lock && (c >= 7) && ((c - 7) % 64 == 0);
      fnum = (c <= 454) ? 10'((c - 71) / 64) : 10'((c - 583) / 64);
      mask = (c >= 560) ? 8'hA5 : 8'hFF;
    end else begin
      hd   = (c == 7) || (c == 71);
      lock = (c >= 71);
      fs   = (c == 71);
      fnum = 10'd0;
      mask = 8'hFF;
    end
    bs3 = 3'(bs);
    c16 = 16'(c);
    i_data_iq  = (bs == 3) ? 32'h0100_0100 : {13'd0, bs3, c16};
    i_fram_hd  = hd;
    i_ant8_sel = (bs == 0);
    i_ant_mask = mask;
    i_pwr_ant  = 3'd3;
    if (lock && mask[bs]) begin
      e.iq = i_data_iq; e.idx = bs3; e.fs = fs; e.fnum = fnum;
      sb_q.push_back(e);
    end
`ifdef LTE_UL_ANT_PWR_EN
    if (fs) pw_q.push_back((epoch == 0 && c != 71) ? 52'd1048576 : 52'd0);
`endif
  endtask

  // Status checks; at cycle c the outputs reflect the input driven at c-2.
  task automatic checkpoint(input int epoch, input int c);
    if (epoch == 0) begin
      case (c)
        8:   chk("st_hunt",      64'(o_sync_st), 64'd0);
        9:   chk("st_check",     64'(o_sync_st), 64'd1);
        20:  chk("slot_err_0",   64'(o_slot_err), 64'd0);
        72:  chk("st_check2",    64'(o_sync_st), 64'd1);
        73:  chk("st_lock",      64'(o_sync_st), 64'd2);
        200: chk("sync_err_0",   64'(o_sync_err), 64'd0);
        201: begin
          chk("sync_err_fly",  64'(o_sync_err), 64'd1);
          chk("st_fly_lock",   64'(o_sync_st), 64'd2);
        end
        456: begin
          chk("st_pre_drop",   64'(o_sync_st), 64'd2);
          chk("sync_err_3",    64'(o_sync_err), 64'd3);
        end
        457: begin
          chk("st_drop_hunt",  64'(o_sync_st), 64'd0);
          chk("sync_err_4",    64'(o_sync_err), 64'd4);
        end
        521: chk("st_recheck",   64'(o_sync_st), 64'd1);
        585: chk("st_relock",    64'(o_sync_st), 64'd2);
        603: chk("slot_err_pre", 64'(o_slot_err), 64'd0);
        604: chk("slot_err_1",   64'(o_slot_err), 64'd1);
        default: ;
      endcase
    end else begin
      case (c)
        8:  chk("rst_st_hunt",  64'(o_sync_st), 64'd0);
        9:  chk("rst_st_check", 64'(o_sync_st), 64'd1);
        72: chk("rst_st_chk2",  64'(o_sync_st), 64'd1);
        73: begin
          chk("rst_st_lock",  64'(o_sync_st), 64'd2);
          chk("rst_errs",     {32'(o_sync_err), 32'(o_slot_err)}, 64'd0);
        end
        default: ;
      endcase
    end
  endtask

  // Monitor: pops the scoreboard on every valid output sample.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!asy_rst) begin
        if (o_ant_vld) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_vld got idx=%0d iq=%0h exp no sample", o_ant_idx, o_ant_iq);
          end else begin
            mon_e = sb_q.pop_front();
            chk("ant_iq",    64'(o_ant_iq), 64'(mon_e.iq));
            chk("ant_idx",   64'(o_ant_idx), 64'(mon_e.idx));
            chk("frm_start", 64'(o_frm_start), 64'(mon_e.fs));
            if (mon_e.fs) chk("frm_num", 64'(o_frm_num), 64'(mon_e.fnum));
          end
        end else begin
          chk("frm_start_idle", 64'(o_frm_start), 64'd0);
        end
`ifdef LTE_UL_ANT_PWR_EN
        if (o_pwr_vld) begin
          if (pw_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pwr got=%0d exp none", o_pwr_acc);
          end else begin
            mon_p = pw_q.pop_front();
            chk("pwr_acc", 64'(o_pwr_acc), 64'(mon_p));
          end
        end
`else
        if (o_frm_start) chk("pwr_off", {11'd0, o_pwr_vld, o_pwr_acc}, 64'd0);
`endif
      end
    end
  end

  initial begin
    asy_rst    = 1'b1;
    i_data_iq  = 32'd0;
    i_fram_hd  = 1'b0;
    i_ant8_sel = 1'b0;
    i_ant_mask = 8'd0;
    i_pwr_ant  = 3'd3;
    repeat (3) @(negedge clk);
    #1;
    chk("por_state", {o_ant_iq, 16'(o_sync_err), 8'(o_sync_st), 8'(o_ant_vld)}, 64'd0);
    @(negedge clk);
    asy_rst = 1'b0;
    for (int c = 0; c <= 720; c++) begin
      checkpoint(0, c);
      drive(0, c);
      @(negedge clk);
    end

    // Reset asserted mid-LOCK must clear outputs without a clock edge.
    asy_rst    = 1'b1;
    i_fram_hd  = 1'b0;
    i_ant8_sel = 1'b0;
    i_ant_mask = 8'd0;
    #1;
    chk("rst_iq_idx",   {o_ant_iq, 29'd0, o_ant_idx}, 64'd0);
    chk("rst_vld_fs",   {62'd0, o_ant_vld, o_frm_start}, 64'd0);
    chk("rst_frm_num",  64'(o_frm_num), 64'd0);
    chk("rst_sync_st",  64'(o_sync_st), 64'd0);
    chk("rst_counters", {32'(o_sync_err), 32'(o_slot_err)}, 64'd0);
    chk("rst_pwr",      {11'd0, o_pwr_vld, o_pwr_acc}, 64'd0);
    sb_q.delete();
    pw_q.delete();
    @(negedge clk);
    asy_rst = 1'b0;
    for (int c = 0; c <= 80; c++) begin
      checkpoint(1, c);
      drive(1, c);
      @(negedge clk);
    end
    i_fram_hd  = 1'b0;
    i_ant8_sel = 1'b0;
    i_ant_mask = 8'd0;
    repeat (8) @(negedge clk);
    chk("sb_drained",  64'(sb_q.size()), 64'd0);
    chk("pwr_drained", 64'(pw_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
